// File: rtl/scr1_dmem_tcm_resp_pkg.sv
// Shared types for the DMEM TCM responder slice.
// Holds the memory-interface enums (command, access width, response), the
// interface widths and the responder FSM state encoding.
package scr1_dmem_tcm_resp_pkg;

  localparam int SCR1_DMEM_AWIDTH   = 32;
  localparam int SCR1_DMEM_DWIDTH   = 32;
  localparam int SCR1_DMEM_BE_WIDTH = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dmem_tcm_state_e;

endpackage

// File: rtl/scr1_dmem_tcm_resp_lane_align.sv
// Combinational byte-lane steering for a 32-bit DMEM responder.
// Request side: byte enables and left-shifted store data from width/offset.
// Response side: raw SRAM word shifted right by the latched offset and zeroed
// above the access width.
// Ports:
//   req_width, req_offs, req_wdata -> be, wdata_lane   (store path)
//   rsp_width, rsp_offs, rdata_raw -> rdata_aligned    (load path)
module scr1_dmem_lane_align
  import scr1_dmem_tcm_resp_pkg::*;
(
  input  type_scr1_mem_width_e          req_width,
  input  logic [1:0]                    req_offs,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   req_wdata,
  output logic [SCR1_DMEM_BE_WIDTH-1:0] be,
  output logic [SCR1_DMEM_DWIDTH-1:0]   wdata_lane,
  input  type_scr1_mem_width_e          rsp_width,
  input  logic [1:0]                    rsp_offs,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   rdata_raw,
  output logic [SCR1_DMEM_DWIDTH-1:0]   rdata_aligned
);

  logic [SCR1_DMEM_DWIDTH-1:0] rdata_shift;

  always_comb begin
    be = '0;
    case (req_width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << req_offs;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << req_offs;
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
  end

  assign wdata_lane  = req_wdata << {req_offs, 3'b000};
  assign rdata_shift = rdata_raw >> {rsp_offs, 3'b000};

  always_comb begin
    rdata_aligned = '0;
    case (rsp_width)
      SCR1_MEM_WIDTH_BYTE:  rdata_aligned = {24'd0, rdata_shift[7:0]};
      SCR1_MEM_WIDTH_HWORD: rdata_aligned = {16'd0, rdata_shift[15:0]};
      SCR1_MEM_WIDTH_WORD:  rdata_aligned = rdata_shift;
      default:              rdata_aligned = '0;
    endcase
  end

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// DMEM responder serving one initiator from a single-port synchronous SRAM.
// One request in flight at a time; range/alignment errors are answered with
// RDY_ER without touching the SRAM. Response latency is 1 + WAIT_STATES.
//
// Handshake: a request transfers on a cycle where dmem_req & dmem_req_ack are
// both high; dmem_req_ack depends only on responder state, never on request
// content, and dmem_resp is a single-cycle pulse that is never issued in the
// acceptance cycle.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   dmem_req/cmd/width/addr/wdata      request from the LSU
//   dmem_req_ack                       request accepted when high with dmem_req
//   dmem_rdata, dmem_resp              right-aligned load data and status
//   sram_cs/we/be/addr/wdata           SRAM command (issued in accept cycle)
//   sram_rdata                         SRAM read data, one cycle after read
module scr1_dmem_tcm_resp
  import scr1_dmem_tcm_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dmem_req,
  input  type_scr1_mem_cmd_e              dmem_cmd,
  input  type_scr1_mem_width_e            dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]     dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]     dmem_wdata,
  output logic                            dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0]     dmem_rdata,
  output type_scr1_mem_resp_e             dmem_resp,
  output logic                            sram_cs,
  output logic                            sram_we,
  output logic [SCR1_DMEM_BE_WIDTH-1:0]   sram_be,
  output logic [$clog2(MEM_BYTES)-3:0]    sram_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]     sram_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]     sram_rdata
);

  localparam int AW = $clog2(MEM_BYTES) - 2;

  dmem_tcm_state_e      state, state_next;
  logic                 ready_r;
  logic [3:0]           cnt;
  type_scr1_mem_cmd_e   cmd_r;
  type_scr1_mem_width_e width_r;
  logic [1:0]           offs_r;
  logic                 err_r;
  logic [31:0]          rdata_r;

  logic [31:0] offset;
  logic        out_of_range;
  logic        misalign;
  logic        req_err;
  logic        accept;
  logic        first_busy;
  logic        resp_cycle;
  logic        rd_ok_r;
  logic [31:0] rdata_aligned;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset       = dmem_addr - BASE_ADDR;
  assign out_of_range = (offset >= 32'(MEM_BYTES));

  always_comb begin
    misalign = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  misalign = 1'b0;
      SCR1_MEM_WIDTH_HWORD: misalign = dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:  misalign = |dmem_addr[1:0];
      default:              misalign = 1'b1;  // illegal width code
    endcase
  end

  assign req_err      = out_of_range | misalign;
  assign dmem_req_ack = ready_r & (state == ST_IDLE);
  assign accept       = dmem_req & dmem_req_ack;

  assign sram_cs   = accept & ~req_err;
  assign sram_we   = (dmem_cmd == SCR1_MEM_CMD_WR);
  assign sram_addr = offset[AW+1:2];

  scr1_dmem_lane_align u_lane_align (
    .req_width     (dmem_width),
    .req_offs      (dmem_addr[1:0]),
    .req_wdata     (dmem_wdata),
    .be            (sram_be),
    .wdata_lane    (sram_wdata),
    .rsp_width     (width_r),
    .rsp_offs      (offs_r),
    .rdata_raw     (sram_rdata),
    .rdata_aligned (rdata_aligned)
  );

  assign first_busy = (state == ST_BUSY) && (cnt == 4'd0);
  assign resp_cycle = (state == ST_BUSY) && (cnt == 4'(WAIT_STATES));
  assign rd_ok_r    = ~err_r & (cmd_r == SCR1_MEM_CMD_RD);

  // SRAM data is only valid in the first BUSY cycle; with wait states it is
  // held in rdata_r until the response cycle.
  assign dmem_rdata = (resp_cycle & rd_ok_r)
                    ? ((WAIT_STATES == 0) ? rdata_aligned : rdata_r)
                    : 32'd0;

  always_comb begin
    state_next = state;
    dmem_resp  = SCR1_MEM_RESP_IDLE;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (resp_cycle) begin
          dmem_resp  = err_r ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      ready_r <= 1'b1;
      state   <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      cmd_r   <= SCR1_MEM_CMD_RD;
      width_r <= SCR1_MEM_WIDTH_BYTE;
      offs_r  <= 2'b00;
      err_r   <= 1'b0;
    end else if (accept) begin
      cnt     <= 4'd0;
      cmd_r   <= dmem_cmd;
      width_r <= dmem_width;
      offs_r  <= dmem_addr[1:0];
      err_r   <= req_err;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'd0;
    end else if (first_busy && rd_ok_r) begin
      rdata_r <= rdata_aligned;
    end
  end

endmodule

// File: tb/tb_scr1_dmem_tcm_resp.sv
module tb_scr1_dmem_tcm_resp;
  import scr1_dmem_tcm_resp_pkg::*;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam int unsigned TB_MEM  = 65536;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic                 sel;
  logic                 req0, req1;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata;

  // per-instance outputs (0: WAIT_STATES=0, 1: WAIT_STATES=3)
  logic ack0, ack1, cs0, cs1, we0, we1;
  logic [3:0] be0, be1;
  logic [13:0] sa0, sa1;
  logic [31:0] swd0, swd1, srd0, srd1, rd0, rd1;
  type_scr1_mem_resp_e resp0, resp1;

  scr1_dmem_tcm_resp #(.BASE_ADDR(TB_BASE), .MEM_BYTES(TB_MEM), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req0), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(ack0), .dmem_rdata(rd0),
    .dmem_resp(resp0), .sram_cs(cs0), .sram_we(we0), .sram_be(be0), .sram_addr(sa0),
    .sram_wdata(swd0), .sram_rdata(srd0));

  scr1_dmem_tcm_resp #(.BASE_ADDR(TB_BASE), .MEM_BYTES(TB_MEM), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req1), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(ack1), .dmem_rdata(rd1),
    .dmem_resp(resp1), .sram_cs(cs1), .sram_we(we1), .sram_be(be1), .sram_addr(sa1),
    .sram_wdata(swd1), .sram_rdata(srd1));

  logic ack, cs;
  logic [3:0] be;
  logic [31:0] wd, rdata;
  type_scr1_mem_resp_e resp;
  assign ack   = sel ? ack1 : ack0;
  assign cs    = sel ? cs1  : cs0;
  assign be    = sel ? be1  : be0;
  assign wd    = sel ? swd1 : swd0;
  assign rdata = sel ? rd1  : rd0;
  assign resp  = sel ? resp1 : resp0;

  // ---------------- shared SRAM model (one memory, two ports used one at a time) ----------------
  logic [31:0] mem [0:16383] = '{default: 32'd0};
  always @(posedge clk) begin
    if (cs0) begin
      if (we0) begin
        for (int b = 0; b < 4; b++) if (be0[b]) mem[sa0][b*8 +: 8] <= swd0[b*8 +: 8];
      end else srd0 <= mem[sa0];
    end
    if (cs1) begin
      if (we1) begin
        for (int b = 0; b < 4; b++) if (be1[b]) mem[sa1][b*8 +: 8] <= swd1[b*8 +: 8];
      end else srd1 <= mem[sa1];
    end
  end

  // ---------------- reference model: flat byte array ----------------
  logic [7:0] mb [0:TB_MEM-1] = '{default: 8'd0};
  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  task automatic ref_access(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic exp_err, output logic [31:0] exp_rd);
    longint unsigned la, off;
    int n;
    la  = longint'(a);
    n   = (w == SCR1_MEM_WIDTH_BYTE) ? 1 : (w == SCR1_MEM_WIDTH_HWORD) ? 2 :
          (w == SCR1_MEM_WIDTH_WORD) ? 4 : 0;
    exp_err = (la < longint'(TB_BASE)) || (la >= longint'(TB_BASE) + longint'(TB_MEM)) ||
              (n == 0) || ((la % longint'(n == 0 ? 1 : n)) != 0);
    exp_rd = 32'd0;
    if (!exp_err) begin
      off = la - longint'(TB_BASE);
      for (int i = 0; i < n; i++) begin
        if (c == SCR1_MEM_CMD_WR) mb[off + longint'(i)] = d[i*8 +: 8];
        else exp_rd[i*8 +: 8] = mb[off + longint'(i)];
      end
    end
  endtask

  // ---------------- driver: one access, with handshake/timing checks ----------------
  task automatic do_access(input bit s, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                           input logic [31:0] a, input logic [31:0] d, output bit ok,
                           output logic cs_c, output logic [3:0] be_c, output logic [31:0] wd_c,
                           output type_scr1_mem_resp_e resp_c, output logic [31:0] rd_c);
    int  ws;
    bit  got;
    ws = s ? 3 : 0;
    ok = 0; got = 0; cs_c = 0; be_c = 0; wd_c = 0; resp_c = SCR1_MEM_RESP_IDLE; rd_c = 0;
    sel = s; dmem_cmd = c; dmem_width = w; dmem_addr = a; dmem_wdata = d;
    if (s) req1 = 1'b1; else req0 = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout inst=%0d addr=%h: ack=%b required 1", s, a, ack);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    cs_c = cs; be_c = be; wd_c = wd;
    n_vec++;
    if (resp !== SCR1_MEM_RESP_IDLE) begin
      n_err++; $display("FAIL resp_in_accept addr=%h: resp=%0d required 0", a, resp);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 1; k <= ws; k++) begin
      @(negedge clk);
      n_vec++;
      if (resp !== SCR1_MEM_RESP_IDLE || cs !== 1'b0) begin
        n_err++; $display("FAIL early_resp k=%0d addr=%h: resp=%0d cs=%b required 0/0", k, a, resp, cs);
      end
    end
    @(negedge clk);
    resp_c = resp; rd_c = rdata;
    n_vec++;
    if (ack !== 1'b0) begin
      n_err++; $display("FAIL ack_in_resp_cycle addr=%h: ack=%b required 0", a, ack);
    end
    @(negedge clk);
    n_vec++;
    if (resp !== SCR1_MEM_RESP_IDLE || ack !== 1'b1 || rdata !== 32'd0) begin
      n_err++;
      $display("FAIL after_resp addr=%h: resp=%0d ack=%b rdata=%h required 0/1/0", a, resp, ack, rdata);
    end
    ok = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; sel = 0;
    dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 0; dmem_wdata = 0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (ack0 !== 0 || ack1 !== 0 || cs0 !== 0 || cs1 !== 0 ||
          resp0 !== SCR1_MEM_RESP_IDLE || resp1 !== SCR1_MEM_RESP_IDLE || rd0 !== 0) begin
        n_err++;
        $display("FAIL reset_state: ack=%b%b cs=%b%b resp=%0d/%0d rdata=%h required 0", ack0, ack1,
                 cs0, cs1, resp0, resp1, rd0);
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ack0 !== 0 || ack1 !== 0) begin
      n_err++; $display("FAIL ack_release_cycle: ack=%b%b required 00", ack0, ack1);
    end
    @(negedge clk);
    n_vec++;
    if (ack0 !== 1 || ack1 !== 1) begin
      n_err++; $display("FAIL ack_after_release: ack=%b%b required 11", ack0, ack1);
    end
    req0 = 1'b0; req1 = 1'b0;  // drop before the edge: nothing accepted
    @(negedge clk);
    n_vec++;
    if (resp0 !== SCR1_MEM_RESP_IDLE || resp1 !== SCR1_MEM_RESP_IDLE) begin
      n_err++; $display("FAIL no_spurious_resp: resp=%0d/%0d required 0", resp0, resp1);
    end
  endtask

  task automatic test_misaligned_store();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r; type_scr1_mem_resp_e rs;
    do_access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h106, 32'hDEADBEEF, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (rs !== SCR1_MEM_RESP_RDY_ER || c !== 1'b0) begin
        n_err++; $display("FAIL misaligned_sw: resp=%0d cs=%b required 2/0", rs, c);
      end
    end
  endtask

  task automatic test_byte_store();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r, er; logic ee; type_scr1_mem_resp_e rs;
    ref_access(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'hA5, ee, er);
    do_access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0000_00A5, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (c !== 1 || b !== 4'b1000 || w !== 32'hA500_0000 || rs !== SCR1_MEM_RESP_RDY_OK) begin
        n_err++;
        $display("FAIL sb_lanes: cs=%b be=%b wdata=%h resp=%0d required 1/1000/a5000000/1", c, b, w, rs);
      end
    end
  endtask

  task automatic test_load_lanes();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r, er; logic ee; type_scr1_mem_resp_e rs;
    ref_access(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h800, 32'h8899AABB, ee, er);
    do_access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h800, 32'h8899AABB, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (c !== 1 || b !== 4'b1111 || w !== 32'h8899AABB || rs !== SCR1_MEM_RESP_RDY_OK) begin
        n_err++; $display("FAIL sw_word: cs=%b be=%b wdata=%h resp=%0d required 1/1111/8899aabb/1", c, b, w, rs);
      end
    end
    do_access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h802, 32'hFFFF_FFFF, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (rs !== SCR1_MEM_RESP_RDY_OK || r !== 32'h0000_8899) begin
        n_err++; $display("FAIL lh_802: resp=%0d rdata=%h required 1/00008899", rs, r);
      end
    end
    do_access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h801, 32'h0, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (rs !== SCR1_MEM_RESP_RDY_OK || r !== 32'h0000_00AA) begin
        n_err++; $display("FAIL lb_801: resp=%0d rdata=%h required 1/000000aa", rs, r);
      end
    end
  endtask

  task automatic test_wait_states();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r, er, v; logic ee; type_scr1_mem_resp_e rs;
    v = $urandom;
    ref_access(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, v, ee, er);
    do_access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, v, ok, c, b, w, rs, r);
    ref_access(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, ee, er);
    do_access(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, ok, c, b, w, rs, r);
    if (ok) begin
      n_vec++;
      if (rs !== SCR1_MEM_RESP_RDY_OK || r !== er || c !== 1'b1) begin
        n_err++; $display("FAIL lw_wait3: resp=%0d rdata=%h cs=%b required 1/%h/1", rs, r, c, er);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r; type_scr1_mem_resp_e rs;
    logic [31:0] addrs [2];
    addrs[0] = TB_BASE + TB_MEM;
    addrs[1] = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      do_access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, addrs[i], 32'h0, ok, c, b, w, rs, r);
      if (ok) begin
        n_vec++;
        if (rs !== SCR1_MEM_RESP_RDY_ER || c !== 1'b0 || r !== 32'd0) begin
          n_err++; $display("FAIL out_of_range addr=%h: resp=%0d cs=%b rdata=%h required 2/0/0",
                            addrs[i], rs, c, r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic c; logic [3:0] b; logic [31:0] w, r, a, d, er; logic ee;
    logic [33:0] e; type_scr1_mem_resp_e rs, exp_rs;
    type_scr1_mem_cmd_e cm; type_scr1_mem_width_e wi; bit s;
    for (int i = 0; i < 80; i++) begin
      s  = 1'($urandom_range(0, 1));
      cm = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      wi = ($urandom_range(0, 7) == 0) ? SCR1_MEM_WIDTH_ERROR
                                       : type_scr1_mem_width_e'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = TB_BASE + TB_MEM + 32'($urandom_range(0, 15));
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 63));
      endcase
      d = $urandom;
      ref_access(cm, wi, a, d, ee, er);
      exp_q.push_back({ee, ~ee, er});
      do_access(s, cm, wi, a, d, ok, c, b, w, rs, r);
      e = exp_q.pop_front();
      if (ok) begin
        exp_rs = e[33] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        n_vec++;
        if (rs !== exp_rs || r !== e[31:0] || c !== e[32]) begin
          n_err++;
          $display("FAIL rand[%0d] inst=%0d cmd=%0d w=%0d addr=%h: resp=%0d rdata=%h cs=%b required %0d/%h/%b",
                   i, s, cm, wi, a, rs, r, c, exp_rs, e[31:0], e[32]);
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    bit got;
    got = 0;
    sel = 1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 32'h10;
    req1 = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ack1 === 1'b1) got = 1;
    end
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL busy_ack_timeout: ack=%b required 1", ack1);
    end
    @(posedge clk); #1; req1 = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (resp1 !== SCR1_MEM_RESP_IDLE || ack1 !== 1'b0) begin
        n_err++; $display("FAIL reset_busy_hold: resp=%0d ack=%b required 0/0", resp1, ack1);
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ack1 !== 1'b0 || resp1 !== SCR1_MEM_RESP_IDLE) begin
      n_err++; $display("FAIL reset_busy_release: ack=%b resp=%0d required 0/0", ack1, resp1);
    end
    @(negedge clk);
    n_vec++;
    if (ack1 !== 1'b1) begin
      n_err++; $display("FAIL reset_busy_ack: ack=%b required 1", ack1);
    end
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (resp1 !== SCR1_MEM_RESP_IDLE || rd1 !== 32'd0) begin
        n_err++; $display("FAIL dropped_txn_resp: resp=%0d rdata=%h required 0/0", resp1, rd1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sel = 1'b0;
    dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 0; dmem_wdata = 0;
    test_reset();
    test_misaligned_store();
    test_byte_store();
    test_load_lanes();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
